// File: rtl/data_pack_ctrl.sv
// rtl/data_pack_ctrl.sv - beat-to-pack sequencer between DDR reader, packer and destination groups
//
// Purpose:
//   Accepts BEATS DDR beats per pack (or synthesises BEATS zero beats in pad
//   mode), strobes each one into the packer, then offers the finished pack to
//   one destination group picked round-robin from the job's group mask.
//   Repeats until cfg_num_pack packs are delivered, then pulses done.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   cfg_start    one-cycle job start pulse (honoured only when idle)
//   cfg_num_pack packs in the job, latched at start
//   cfg_grp_mask groups eligible to receive packs, latched at start
//   cfg_pad      zero-pad job with no DDR traffic, latched at start
//   up_vld       DDR beat valid
//   up_rdy       DDR beat accept
//   pk_vld       beat strobe to packer
//   pk_pad       packer substitutes zero for this beat
//   dn_vld       one-hot pack valid to the destination group
//   dn_rdy       per-group pack accept
//   busy         job in progress
//   done         one-cycle job-complete pulse

module data_pack_ctrl #(
  parameter int BE_PARALLELISM          = 32,
  parameter int PARALLELISM_PER_CONTROL = 4,
  parameter int DATA_WIDTH              = 16,
  parameter int BAND_WIDTH              = 256,
  parameter int LEN_WIDTH               = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                cfg_start,
  input  logic [LEN_WIDTH-1:0]                                cfg_num_pack,
  input  logic [BE_PARALLELISM/PARALLELISM_PER_CONTROL-1:0]   cfg_grp_mask,
  input  logic                                                cfg_pad,
  input  logic                                                up_vld,
  output logic                                                up_rdy,
  output logic                                                pk_vld,
  output logic                                                pk_pad,
  output logic [BE_PARALLELISM/PARALLELISM_PER_CONTROL-1:0]   dn_vld,
  input  logic [BE_PARALLELISM/PARALLELISM_PER_CONTROL-1:0]   dn_rdy,
  output logic                                                busy,
  output logic                                                done
);

  localparam int NUM_GRP = BE_PARALLELISM / PARALLELISM_PER_CONTROL;
  localparam int BEATS   = 2 * DATA_WIDTH * BE_PARALLELISM / BAND_WIDTH;
  localparam int BCW     = $clog2(BEATS) + 1;
  localparam int GW      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [BCW-1:0]       r_beat_cnt;
  logic [LEN_WIDTH-1:0] r_pack_cnt;
  logic [GW-1:0]        r_last_grp;
  logic [LEN_WIDTH-1:0] r_num_pack;
  logic [NUM_GRP-1:0]   r_grp_mask;
  logic                 r_pad;

  logic                 w_beat;
  logic                 w_last_beat;
  logic [GW-1:0]        w_grp;
  logic [NUM_GRP-1:0]   w_grp_onehot;
  logic                 w_dn_hs;
  logic [LEN_WIDTH-1:0] w_pack_cnt_inc;
  logic                 w_degenerate;

  // A beat is consumed every FILL cycle in pad mode, otherwise only when DDR offers one.
  assign w_beat         = (r_state == S_FILL) && (r_pad || up_vld);
  assign w_last_beat    = (r_beat_cnt == BCW'(BEATS - 1));
  assign w_pack_cnt_inc = r_pack_cnt + LEN_WIDTH'(1);
  assign w_degenerate   = (cfg_num_pack == '0) || (cfg_grp_mask == '0);

  // Round-robin pick: first set mask bit starting one past the last grant.
  // r_last_grp only moves on a handshake, so w_grp is stable while a pack waits.
  always_comb begin
    logic [GW-1:0] v_idx;
    logic          v_found;
    v_idx   = '0;
    v_found = 1'b0;
    w_grp   = r_last_grp;
    for (int i = 1; i <= NUM_GRP; i++) begin
      v_idx = GW'((int'(r_last_grp) + i) % NUM_GRP);
      if (!v_found && r_grp_mask[v_idx]) begin
        w_grp   = v_idx;
        v_found = 1'b1;
      end
    end
  end

  assign w_grp_onehot = NUM_GRP'(1) << w_grp;
  assign w_dn_hs      = (r_state == S_ISSUE) && dn_rdy[w_grp];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and outputs
  always_comb begin
    w_state_nxt = r_state;
    up_rdy      = 1'b0;
    pk_vld      = 1'b0;
    pk_pad      = 1'b0;
    dn_vld      = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_state_nxt = w_degenerate ? S_DONE : S_FILL;
        end
      end

      S_FILL: begin
        busy   = 1'b1;
        up_rdy = !r_pad;
        pk_vld = r_pad ? 1'b1 : up_vld;
        pk_pad = r_pad;
        // The extra cycle before ISSUE lets the packer register the last beat.
        if (w_beat && w_last_beat) begin
          w_state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        busy   = 1'b1;
        dn_vld = w_grp_onehot;
        if (w_dn_hs) begin
          w_state_nxt = (w_pack_cnt_inc == r_num_pack) ? S_DONE : S_FILL;
        end
      end

      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Keep all outputs quiet during the reset cycle itself.
    if (rst) begin
      up_rdy = 1'b0;
      pk_vld = 1'b0;
      pk_pad = 1'b0;
      dn_vld = '0;
      busy   = 1'b0;
      done   = 1'b0;
    end
  end

  // Job configuration and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_pack_cnt <= '0;
      r_last_grp <= GW'(NUM_GRP - 1);
      r_num_pack <= '0;
      r_grp_mask <= '0;
      r_pad      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_num_pack <= cfg_num_pack;
            r_grp_mask <= cfg_grp_mask;
            r_pad      <= cfg_pad;
            r_beat_cnt <= '0;
            r_pack_cnt <= '0;
          end
        end

        S_FILL: begin
          if (w_beat) begin
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + BCW'(1);
          end
        end

        S_ISSUE: begin
          if (w_dn_hs) begin
            r_last_grp <= w_grp;
            r_pack_cnt <= w_pack_cnt_inc;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_pack_ctrl.sv
// tb/tb_data_pack_ctrl.sv - directed self-checking bench for data_pack_ctrl

module tb_data_pack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [15:0] cfg_num_pack;
  logic [7:0]  cfg_grp_mask;
  logic        cfg_pad;
  logic        up_vld;
  logic        up_rdy;
  logic        pk_vld;
  logic        pk_pad;
  logic [7:0]  dn_vld;
  logic [7:0]  dn_rdy;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_pack_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_num_pack (cfg_num_pack),
    .cfg_grp_mask (cfg_grp_mask),
    .cfg_pad      (cfg_pad),
    .up_vld       (up_vld),
    .up_rdy       (up_rdy),
    .pk_vld       (pk_vld),
    .pk_pad       (pk_pad),
    .dn_vld       (dn_vld),
    .dn_rdy       (dn_rdy),
    .busy         (busy),
    .done         (done)
  );

  // Expected output bundle: {up_rdy, pk_vld, pk_pad, busy, done, dn_vld}
  function automatic logic [12:0] mk(input logic ur, input logic pv, input logic pp,
                                     input logic b, input logic d, input logic [7:0] dn);
    return {ur, pv, pp, b, d, dn};
  endfunction

  localparam logic [12:0] EXP_IDLE  = 13'h0000;
  localparam logic [12:0] EXP_FILL  = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
  localparam logic [12:0] EXP_PAD   = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
  localparam logic [12:0] EXP_DONE  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    #1;
    obs = {up_rdy, pk_vld, pk_pad, busy, done, dn_vld};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cursor convention: every task starts and ends just after a negedge.
  task automatic start(input string tag, input logic [15:0] num, input logic [7:0] mask,
                       input logic pad);
    cfg_start    = 1'b1;
    cfg_num_pack = num;
    cfg_grp_mask = mask;
    cfg_pad      = pad;
    chk({tag, "_idle_at_start"}, EXP_IDLE);
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic fill(input string tag, input int n, input logic [12:0] exp);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_fill%0d", tag, i), exp);
      @(negedge clk);
    end
  endtask

  task automatic issue(input string tag, input logic [7:0] dn);
    chk({tag, "_issue"}, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, dn));
    @(negedge clk);
  endtask

  task automatic fin(input string tag);
    chk({tag, "_done"}, EXP_DONE);
    @(negedge clk);
    chk({tag, "_idle_after"}, EXP_IDLE);
    @(negedge clk);
  endtask

  logic [7:0] rr_seq [5];

  initial begin
    rst          = 1'b1;
    cfg_start    = 1'b0;
    cfg_num_pack = '0;
    cfg_grp_mask = '0;
    cfg_pad      = 1'b0;
    up_vld       = 1'b0;
    dn_rdy       = 8'hFF;

    @(negedge clk);
    chk("reset_outputs", EXP_IDLE);
    @(negedge clk);
    rst = 1'b0;
    chk("idle_after_reset", EXP_IDLE);
    @(negedge clk);

    // Basic job, single-group mask: two packs both routed to group 0
    up_vld = 1'b1;
    dn_rdy = 8'hFF;
    start("basic", 16'd2, 8'h01, 1'b0);
    fill("basic_p0", 4, EXP_FILL);
    issue("basic_p0", 8'h01);
    fill("basic_p1", 4, EXP_FILL);
    issue("basic_p1", 8'h01);
    fin("basic");

    // Start coincident with reset: reset wins, stays idle
    rst          = 1'b1;
    cfg_start    = 1'b1;
    cfg_num_pack = 16'd3;
    cfg_grp_mask = 8'hFF;
    @(negedge clk);
    rst       = 1'b0;
    cfg_start = 1'b0;
    chk("rst_beats_start", EXP_IDLE);
    @(negedge clk);

    // Round-robin from reset over mask 0xA5
    rr_seq[0] = 8'h01;
    rr_seq[1] = 8'h04;
    rr_seq[2] = 8'h20;
    rr_seq[3] = 8'h80;
    rr_seq[4] = 8'h01;
    start("rr", 16'd5, 8'hA5, 1'b0);
    for (int p = 0; p < 5; p++) begin
      fill($sformatf("rr_p%0d", p), 4, EXP_FILL);
      issue($sformatf("rr_p%0d", p), rr_seq[p]);
    end
    fin("rr");

    // Backpressure: last grant was group 0, mask 0x0C selects group 2.
    // Other groups stay ready and must be ignored.
    start("bp", 16'd1, 8'h0C, 1'b0);
    fill("bp", 4, EXP_FILL);
    dn_rdy = 8'hFB;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_hold%0d", i), mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04));
      @(negedge clk);
    end
    dn_rdy = 8'hFF;
    issue("bp_release", 8'h04);
    fin("bp");

    // Pad job: no DDR valid, a stray start mid-job must be ignored.
    // Last grant was group 2, mask 0x01 wraps around to group 0.
    up_vld = 1'b0;
    start("pad", 16'd1, 8'h01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cfg_start    = (i == 1);
      cfg_pad      = 1'b0;
      cfg_num_pack = 16'd9;
      chk($sformatf("pad_fill%0d", i), EXP_PAD);
      @(negedge clk);
    end
    cfg_start = 1'b0;
    issue("pad", 8'h01);
    fin("pad");

    // Degenerate configurations
    up_vld = 1'b1;
    start("zero_num", 16'd0, 8'hFF, 1'b0);
    fin("zero_num");
    start("zero_mask", 16'd3, 8'h00, 1'b0);
    fin("zero_mask");

    // Abort after two beats, then a clean single-pack job
    start("abort", 16'd2, 8'h01, 1'b0);
    fill("abort", 2, EXP_FILL);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quiet", EXP_IDLE);
    @(negedge clk);
    chk("abort_no_done", EXP_IDLE);
    @(negedge clk);
    start("post_abort", 16'd1, 8'h01, 1'b0);
    fill("post_abort", 4, EXP_FILL);
    issue("post_abort", 8'h01);
    fin("post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
